// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline stage of the pipelined RISC-V core.
//
// The stage registers the decode outputs, including the register file data
// read in ID, into the ID/EX register. It also works out load-use and RAW
// hazards and stalls IF/ID by inserting bubbles. A taken branch or jump
// flushes the stage. The stage then presents the EX operands, which are
// forwarded when forwarding is built in.
//
// The register file writes on the falling clock edge. A WB write and an ID
// read in the same cycle therefore already agree inside the register file,
// so there is no WB-to-ID bypass here.
//
// Build option:
//   IDEX_FORWARD_EN  defined   : EX/MEM and MEM/WB forwarding onto ex_op_a/b.
//                               Only a load-use dependence stalls.
//                    undefined : no forwarding. A dependent instruction
//                               stalls until its producer reaches WB, which
//                               takes up to 2 bubbles.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   id_*                     decode-stage instruction fields and register data
//   flush                    branch/jump taken in EX; loads a bubble
//   exm_rd/_reg_wen/_result  EX/MEM destination, write enable, ALU result
//   mwb_rd/_reg_wen/_data    MEM/WB destination, write enable, writeback data
//   stall_if_id              hold PC and IF/ID (combinational)
//   ex_*                     registered ID/EX contents
//   ex_op_a, ex_op_b         EX operands (combinational from registered state)
//   stall_count              saturating count of stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [31:0]       id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [31:0]       id_data1,
   input  logic [31:0]       id_data2,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_mem_read,
   input  logic              id_reg_wen,
   input  logic              flush,
   input  logic [4:0]        exm_rd,
   input  logic              exm_reg_wen,
   input  logic [31:0]       exm_result,
   input  logic [4:0]        mwb_rd,
   input  logic              mwb_reg_wen,
   input  logic [31:0]       mwb_data,
   output logic              stall_if_id,
   output logic              ex_valid,
   output logic              ex_mem_read,
   output logic              ex_reg_wen,
   output logic [31:0]       ex_pc,
   output logic [31:0]       ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [31:0]       ex_op_a,
   output logic [31:0]       ex_op_b,
   output logic [CNT_W-1:0]  stall_count
);

   // ID/EX register state
   logic              valid_q,    valid_d;
   logic              mem_read_q, mem_read_d;
   logic              reg_wen_q,  reg_wen_d;
   logic [31:0]       pc_q,       pc_d;
   logic [31:0]       imm_q,      imm_d;
   logic [4:0]        rs1_q,      rs1_d;
   logic [4:0]        rs2_q,      rs2_d;
   logic [4:0]        rd_q,       rd_d;
   logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
   logic [31:0]       data1_q,    data1_d;
   logic [31:0]       data2_q,    data2_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;

   // ---------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------
   logic hit_ex;     // ID reads the register that the EX instruction writes
   logic load_use;
   logic raw_extra;

   // An x0 index never matches, so x0 can never be a hazard source.
   assign hit_ex = id_valid &
                   ((id_use_rs1 && id_rs1 != 5'd0 && id_rs1 == rd_q) ||
                    (id_use_rs2 && id_rs2 != 5'd0 && id_rs2 == rd_q));

   assign load_use = valid_q & mem_read_q & reg_wen_q & hit_ex;

`ifdef IDEX_FORWARD_EN
   assign raw_extra = 1'b0;

   // The rd_q != 0 test is folded into hit_ex, which already excludes x0.
   logic unused_fwd;
   assign unused_fwd = 1'b0;
`else
   logic hit_exm;

   assign hit_exm = id_valid &
                    ((id_use_rs1 && id_rs1 != 5'd0 && id_rs1 == exm_rd) ||
                     (id_use_rs2 && id_rs2 != 5'd0 && id_rs2 == exm_rd));

   // Without forwarding, the ID instruction waits for its producer to leave
   // both EX and MEM. The falling-edge register file write in WB then covers
   // the rest.
   assign raw_extra = (valid_q & reg_wen_q & (rd_q != 5'd0) & hit_ex) |
                      (exm_reg_wen & (exm_rd != 5'd0) & hit_exm);

   // These inputs are only consumed by the forwarding network.
   logic unused_fwd;
   assign unused_fwd = ^{exm_result, mwb_rd, mwb_reg_wen, mwb_data};
`endif

   // A flush overrides any hazard: the ID instruction is being discarded anyway.
   assign stall_if_id = (load_use | raw_extra) & ~flush;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // Default is a bubble with every field driven to zero.
      valid_d    = 1'b0;
      mem_read_d = 1'b0;
      reg_wen_d  = 1'b0;
      pc_d       = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      ctrl_d     = '0;
      data1_d    = '0;
      data2_d    = '0;

      if (!flush && !stall_if_id) begin
         // Gating the control bits with id_valid keeps an invalid capture a
         // clean bubble, so it cannot trigger hazards or side effects.
         valid_d    = id_valid;
         mem_read_d = id_mem_read & id_valid;
         reg_wen_d  = id_reg_wen & id_valid;
         ctrl_d     = id_valid ? id_ctrl : '0;
         pc_d       = id_pc;
         imm_d      = id_imm;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         data1_d    = id_data1;
         data2_d    = id_data2;
      end

      cnt_d = cnt_q;
      if (stall_if_id && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         mem_read_q <= 1'b0;
         reg_wen_q  <= 1'b0;
         pc_q       <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         ctrl_q     <= '0;
         data1_q    <= '0;
         data2_q    <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         mem_read_q <= mem_read_d;
         reg_wen_q  <= reg_wen_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         ctrl_q     <= ctrl_d;
         data1_q    <= data1_d;
         data2_q    <= data2_d;
         cnt_q      <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Operand selection
   // ---------------------------------------------------------------------
`ifdef IDEX_FORWARD_EN
   always_comb begin
      // EX/MEM holds the younger result, so it takes priority over MEM/WB.
      ex_op_a = data1_q;
      if (exm_reg_wen && exm_rd != 5'd0 && exm_rd == rs1_q)
         ex_op_a = exm_result;
      else if (mwb_reg_wen && mwb_rd != 5'd0 && mwb_rd == rs1_q)
         ex_op_a = mwb_data;

      ex_op_b = data2_q;
      if (exm_reg_wen && exm_rd != 5'd0 && exm_rd == rs2_q)
         ex_op_b = exm_result;
      else if (mwb_reg_wen && mwb_rd != 5'd0 && mwb_rd == rs2_q)
         ex_op_b = mwb_data;
   end
`else
   assign ex_op_a = data1_q;
   assign ex_op_b = data2_q;
`endif

   assign ex_valid    = valid_q;
   assign ex_mem_read = mem_read_q;
   assign ex_reg_wen  = reg_wen_q;
   assign ex_pc       = pc_q;
   assign ex_imm      = imm_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rd       = rd_q;
   assign ex_ctrl     = ctrl_q;
   assign stall_count = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined RISC-V core.
- Captures decode-stage outputs, including data1/data2 read combinationally from the register file, into the ID/EX pipeline register.
- Detects load-use and RAW hazards, stalls IF/ID and inserts bubbles, and handles branch flush.
- Presents forwarded operands to the EX stage.
- The register file writes on the falling clock edge, so a WB write and an ID read in the same cycle already resolve inside the register file. No WB-to-ID bypass exists in this block.

Parameters:
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle passed through.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock for the pipeline register; the register file uses the falling edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_pc  input  32  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  input  5 each  register indices.
- id_use_rs1, id_use_rs2  input  1 each  the instruction actually reads rs1/rs2.
- id_data1, id_data2  input  32 each  register file read data.
- id_imm  input  32  sign-extended immediate.
- id_ctrl  input  CTRL_W  control bundle.
- id_mem_read  input  1  instruction is a load.
- id_reg_wen  input  1  instruction writes rd.
- flush  input  1  branch/jump taken in EX.
- exm_rd  input  5  EX/MEM destination.
- exm_reg_wen  input  1  EX/MEM write enable.
- exm_result  input  32  EX/MEM ALU result.
- mwb_rd  input  5  MEM/WB destination.
- mwb_reg_wen  input  1  MEM/WB write enable.
- mwb_data  input  32  MEM/WB writeback data.
- stall_if_id  output  1  hold PC and IF/ID (combinational).
- ex_valid, ex_mem_read, ex_reg_wen  output  1 each  registered.
- ex_pc, ex_imm  output  32 each  registered.
- ex_rs1, ex_rs2, ex_rd  output  5 each  registered.
- ex_ctrl  output  CTRL_W  registered.
- ex_op_a, ex_op_b  output  32 each  forwarded operands (combinational from registered state).
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, any time including mid-stall):
  - All ex_* registers clear to 0 (a bubble), and stall_count clears to 0.
  - stall_if_id is 0 while the ID/EX register holds the bubble.
- Hazard terms:
  - dep1 = id_valid & id_use_rs1 & id_rs1 != 0 & id_rs1 == R.
  - dep2 is the same term using rs2.
  - hit(R) = dep1 | dep2.
- Load-use:
  - lu = ex_valid & ex_mem_read & ex_reg_wen & hit(ex_rd).
- stall_if_id = (lu | raw_extra) & ~flush. raw_extra is defined under Optional Feature.
- Each rising clk, in priority order:
  - flush: load a bubble (valid, mem_read, reg_wen, ctrl = 0; other fields don't-care, driven 0).
  - Else stall_if_id: load a bubble. The ID instruction is held upstream and re-read from the register file next cycle.
  - Else: capture all id_* fields. A captured instruction with id_valid=0 is a bubble.
- Latency:
  - 1 cycle from ID capture to EX outputs.
  - Each load-use costs exactly 1 bubble.
- Forwarding for ex_op_a (ex_op_b is symmetric on ex_rs2 / captured data2):
  - If exm_reg_wen & exm_rd != 0 & exm_rd == ex_rs1, output exm_result. EX/MEM has priority.
  - Else if mwb_reg_wen & mwb_rd != 0 & mwb_rd == ex_rs1, output mwb_data.
  - Else output the captured id_data1.
- Register x0 is never a forwarding or hazard source.
- stall_count increments on each rising clk where stall_if_id=1 and saturates at all-ones. A flush cycle does not count.
- Simultaneous flush + hazard: flush wins, stall_if_id=0, no count.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined:
  - Forwarding is active as described above.
  - raw_extra = 0.
- Undefined:
  - No forwarding; ex_op_a/ex_op_b are the captured register data.
  - raw_extra = (ex_valid & ex_reg_wen & ex_rd != 0 & hit(ex_rd)) | (exm_reg_wen & exm_rd != 0 & hit(exm_rd)).
  - A dependent instruction therefore stalls up to 2 cycles until its producer reaches WB, where the falling-edge register file write covers it.

Test Plan:
- Reset: assert rst mid-stream while a stall is active.
  - Required: ex_valid=0, stall_if_id=0, stall_count=0 immediately, without waiting for a clock edge.
- Load-use: ex has lw x5 (mem_read=1, rd=5); ID has add x6,x5,x7 with use_rs1=1.
  - Required: stall_if_id=1 for 1 cycle, a bubble enters EX, the add enters the next cycle, and stall_count goes 0->1.
- Forward priority (IDEX_FORWARD_EN defined): ex_rs1=3, exm_rd=3, exm_result=0x11, mwb_rd=3, mwb_data=0x22.
  - Required: ex_op_a=0x11.
  - With exm_reg_wen=0: ex_op_a=0x22.
- x0: exm_rd=0, exm_reg_wen=1, ex_rs1=0, captured data1=0.
  - Required: ex_op_a=0; a load with rd=0 never stalls.
- Flush with hazard: load-use condition present and flush=1.
  - Required: stall_if_id=0, a bubble loads, stall_count unchanged.
- No-forward build (IDEX_FORWARD_EN undefined): addi x4 in EX (reg_wen=1), ID reads x4.
  - Required: stall_if_id=1 for 2 consecutive cycles, then capture; ex_op_a equals the register file value written at the intervening falling edge; stall_count +2.
